// File: rtl/lbist_pkg.sv
// Shared LBIST constants and the pattern-generator state type.
package lbist_pkg;

  localparam int LBIST_W = 8;
  localparam logic [LBIST_W-1:0] LBIST_TAPS = 8'hB8;
  localparam logic [LBIST_W-1:0] LBIST_SEED = 8'h01;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/lbist_tpg_if.sv
// Pattern bus between lbist_tpg (master) and its controller/buffer (slave).
// Seed-load signals exist only with LBIST_TPG_SEED_LOAD_EN defined.
interface lbist_tpg_if;
  import lbist_pkg::*;

  logic               start;
  logic               hold;
  logic [LBIST_W-1:0] pattern;
  logic               pat_valid;
  logic               busy;
  logic               done;
  logic [7:0]         pat_idx;
`ifdef LBIST_TPG_SEED_LOAD_EN
  logic [LBIST_W-1:0] seed_in;
  logic               seed_ld;

  modport master (
    input  start, hold, seed_in, seed_ld,
    output pattern, pat_valid, busy,
    output done, pat_idx
  );

  modport slave (
    output start, hold, seed_in, seed_ld,
    input  pattern, pat_valid, busy,
    input  done, pat_idx
  );
`else
  modport master (
    input  start, hold,
    output pattern, pat_valid, busy,
    output done, pat_idx
  );

  modport slave (
    output start, hold,
    input  pattern, pat_valid, busy,
    input  done, pat_idx
  );
`endif

endinterface

// File: rtl/lbist_lfsr.sv
// Fibonacci LFSR with load/advance/hold; shared by the TPG and the MISR.
module lbist_lfsr #(
  parameter int             W       = 8,
  parameter logic [W-1:0]   TAPS    = 8'hB8,
  parameter logic [W-1:0]   RST_VAL = 8'h01
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         adv,
  output logic [W-1:0] q
);

  logic fb;

  assign fb = ^(q & TAPS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (load) begin
      q <= load_val;
    end else if (adv) begin
      q <= {q[W-2:0], fb};
    end
  end

endmodule

// File: rtl/lbist_tpg.sv
// LBIST test-pattern generator: session FSM, pattern counter, LFSR.
// Optional runtime seed load enabled by LBIST_TPG_SEED_LOAD_EN.
module lbist_tpg
  import lbist_pkg::*;
#(
  parameter int               WIDTH = LBIST_W,
  parameter logic [WIDTH-1:0] TAPS  = LBIST_TAPS,
  parameter logic [WIDTH-1:0] SEED  = LBIST_SEED,
  parameter int               NPAT  = 255
) (
  input  logic       clk,
  input  logic       rst,
  lbist_tpg_if.master io
);

  localparam logic [7:0] LAST = 8'(NPAT - 1);

  state_t           state;
  state_t           nxt;
  logic [7:0]       idx;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] seed_nxt;
  logic             last;
  logic             adv;
  logic             load;

`ifdef LBIST_TPG_SEED_LOAD_EN
  logic [WIDTH-1:0] seed_q;
  logic             seed_we;

  assign seed_we = (state == IDLE) && io.seed_ld;

  // Zero seed would lock the LFSR; substitute the all-but-LSB-zero state.
  always_comb begin
    seed_nxt = seed_q;
    if (seed_we) begin
      if (io.seed_in == '0) begin
        seed_nxt = WIDTH'(1);
      end else begin
        seed_nxt = io.seed_in;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seed_q <= SEED;
    end else if (seed_we) begin
      seed_q <= seed_nxt;
    end
  end
`else
  assign seed_nxt = SEED;
`endif

  assign last = (idx == LAST);
  assign adv  = (state == RUN) && !io.hold && !last;
  assign load = (state != RUN);

  lbist_lfsr #(
    .W       (WIDTH),
    .TAPS    (TAPS),
    .RST_VAL (SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (seed_nxt),
    .adv      (adv),
    .q        (q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (io.start) nxt = RUN;
      RUN:  if (!io.hold && last) nxt = DONE;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Index survives into DONE so it names the last emitted pattern.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (state != RUN) begin
      idx <= '0;
    end else if (adv) begin
      idx <= idx + 8'd1;
    end
  end

  assign io.pattern   = q;
  assign io.pat_valid = (state == RUN) && !io.hold;
  assign io.busy      = (state == RUN);
  assign io.done      = (state == DONE);
  assign io.pat_idx   = idx;

endmodule

// File: tb/tb_lbist_tpg.sv
// Self-checking bench for lbist_tpg: three instances (NPAT 6, 255, 1)
// share stimulus and are compared each cycle against a session model.
module tb_lbist_tpg;
  import lbist_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic hold = 1'b0;
`ifdef LBIST_TPG_SEED_LOAD_EN
  logic [7:0] seed_in = 8'h00;
  logic       seed_ld = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lbist_tpg_if ifa ();
  lbist_tpg_if ifb ();
  lbist_tpg_if ifc ();

  assign ifa.start = start;
  assign ifb.start = start;
  assign ifc.start = start;
  assign ifa.hold  = hold;
  assign ifb.hold  = hold;
  assign ifc.hold  = hold;
`ifdef LBIST_TPG_SEED_LOAD_EN
  assign ifa.seed_in = seed_in;
  assign ifb.seed_in = seed_in;
  assign ifc.seed_in = seed_in;
  assign ifa.seed_ld = seed_ld;
  assign ifb.seed_ld = seed_ld;
  assign ifc.seed_ld = seed_ld;
`endif

  lbist_tpg #(.NPAT(6)) dut_a (
    .clk (clk), .rst (rst), .io (ifa)
  );
  lbist_tpg #(.NPAT(255)) dut_b (
    .clk (clk), .rst (rst), .io (ifb)
  );
  lbist_tpg #(.NPAT(1)) dut_c (
    .clk (clk), .rst (rst), .io (ifc)
  );

  logic [7:0] o_pat [3];
  logic [7:0] o_idx [3];
  logic       o_val [3];
  logic       o_busy [3];
  logic       o_done [3];

  assign o_pat[0] = ifa.pattern;
  assign o_pat[1] = ifb.pattern;
  assign o_pat[2] = ifc.pattern;
  assign o_idx[0] = ifa.pat_idx;
  assign o_idx[1] = ifb.pat_idx;
  assign o_idx[2] = ifc.pat_idx;
  assign o_val[0] = ifa.pat_valid;
  assign o_val[1] = ifb.pat_valid;
  assign o_val[2] = ifc.pat_valid;
  assign o_busy[0] = ifa.busy;
  assign o_busy[1] = ifb.busy;
  assign o_busy[2] = ifc.busy;
  assign o_done[0] = ifa.done;
  assign o_done[1] = ifb.done;
  assign o_done[2] = ifc.done;

  function automatic int npat(input int i);
    case (i)
      0: return 6;
      1: return 255;
      default: return 1;
    endcase
  endfunction

  // k-th state of x^8+x^6+x^5+x^4+1 starting from s.
  function automatic logic [7:0] nth(input logic [7:0] s, input int k);
    logic [7:0] v;
    v = s;
    for (int j = 0; j < k; j++)
      v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    return v;
  endfunction

  task automatic chk(input string nm, input int i,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] t=%0t got=%0h exp=%0h",
               nm, i, $time, got, exp);
    end
  endtask

  // Session model: 0 idle, 1 run, 2 done.
  int         m_mode [3] = '{default: 0};
  int         m_idx  [3] = '{default: 0};
  logic [7:0] m_seed [3] = '{default: 8'h01};

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_mode[i] <= 0;
        m_idx[i]  <= 0;
        m_seed[i] <= 8'h01;
      end else begin
        case (m_mode[i])
          0: begin
`ifdef LBIST_TPG_SEED_LOAD_EN
            if (seed_ld)
              m_seed[i] <= (seed_in == 8'h00) ? 8'h01 : seed_in;
`endif
            if (start) begin
              m_mode[i] <= 1;
              m_idx[i]  <= 0;
            end
          end
          1: if (!hold) begin
            if (m_idx[i] == npat(i) - 1) m_mode[i] <= 2;
            else m_idx[i] <= m_idx[i] + 1;
          end
          default: begin
            m_mode[i] <= 0;
            m_idx[i]  <= 0;
          end
        endcase
      end
    end
  end

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] qc[$];
  int         dcnt [3] = '{default: 0};

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      logic [7:0] e_pat;
      int         e_idx;
      case (m_mode[i])
        0: begin e_pat = m_seed[i]; e_idx = 0; end
        1: begin
          e_pat = nth(m_seed[i], m_idx[i]);
          e_idx = m_idx[i];
        end
        default: begin
          e_pat = nth(m_seed[i], npat(i) - 1);
          e_idx = npat(i) - 1;
        end
      endcase
      chk("pattern", i, 32'(o_pat[i]), 32'(e_pat));
      chk("pat_idx", i, 32'(o_idx[i]), 32'(e_idx));
      chk("pat_valid", i, 32'(o_val[i]),
          32'(m_mode[i] == 1 && !hold));
      chk("busy", i, 32'(o_busy[i]), 32'(m_mode[i] == 1));
      chk("done", i, 32'(o_done[i]), 32'(m_mode[i] == 2));
      if (o_done[i]) dcnt[i]++;
    end
    if (o_val[0]) qa.push_back(o_pat[0]);
    if (o_val[1]) qb.push_back(o_pat[1]);
    if (o_val[2]) qc.push_back(o_pat[2]);
  end

  logic [7:0] lit [6] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23};

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((ifa.busy || ifb.busy || ifc.busy ||
            ifa.done || ifb.done || ifc.done) && n < budget) begin
      tick();
      n++;
    end
    chk("idle_timeout", 0, 32'(n < budget), 32'd1);
  endtask

  task automatic clear_q();
    qa.delete();
    qb.delete();
    qc.delete();
  endtask

  task automatic check_a_lit(input string nm);
    chk({nm, "_len"}, 0, 32'(qa.size()), 32'd6);
    for (int k = 0; k < 6; k++)
      if (k < qa.size()) chk(nm, k, 32'(qa[k]), 32'(lit[k]));
  endtask

  task automatic check_b_full();
    bit seen [256];
    int bad;
    bad = 0;
    for (int k = 0; k < 256; k++) seen[k] = 1'b0;
    foreach (qb[k]) begin
      if (qb[k] == 8'h00 || seen[qb[k]]) bad++;
      seen[qb[k]] = 1'b1;
    end
    chk("b_len", 1, 32'(qb.size()), 32'd255);
    chk("b_distinct", 1, 32'(bad), 32'd0);
  endtask

  initial begin
    int da, db, n, d0;

    // Reset and idle
    tick();
    tick();
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("idle_pat", 0, 32'(ifa.pattern), 32'h01);
      chk("idle_busy", 0, 32'(ifa.busy), 32'd0);
      chk("idle_done", 0, 32'(ifa.done), 32'd0);
    end
    tick();

    // Full sessions on all three instances
    clear_q();
    d0 = dcnt[0];
    pulse_start();
    da = 0;
    db = 0;
    n = 0;
    while (db == 0 && n < 300) begin
      @(negedge clk);
      n++;
      if (ifa.done && da == 0) da = n;
      if (ifb.done) db = n;
    end
    chk("done_a_cycle", 0, 32'(da), 32'd7);
    chk("done_b_cycle", 1, 32'(db), 32'd256);
    tick();
    wait_idle(400);
    check_a_lit("seq_a");
    check_b_full();
    chk("c_len", 2, 32'(qc.size()), 32'd1);
    if (qc.size() > 0) chk("c_pat", 2, 32'(qc[0]), 32'h01);
    chk("a_done_count", 0, 32'(dcnt[0] - d0), 32'd1);

    // Hold while pattern 04 is on the bus
    clear_q();
    pulse_start();
    tick();
    tick();
    hold = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("hold_pat", 0, 32'(ifa.pattern), 32'h04);
      chk("hold_idx", 0, 32'(ifa.pat_idx), 32'd2);
      chk("hold_val", 0, 32'(ifa.pat_valid), 32'd0);
      tick();
    end
    hold = 1'b0;
    wait_idle(400);
    check_a_lit("hold_seq");
    check_b_full();

    // Reset mid-session
    clear_q();
    d0 = dcnt[0];
    pulse_start();
    tick();
    tick();
    tick();
    chk("pre_rst_idx", 0, 32'(ifa.pat_idx), 32'd3);
    rst = 1'b1;
    #1;
    chk("rst_pat", 0, 32'(ifa.pattern), 32'h01);
    chk("rst_idx", 0, 32'(ifa.pat_idx), 32'd0);
    chk("rst_busy", 1, 32'(ifb.busy), 32'd0);
    chk("rst_val", 0, 32'(ifa.pat_valid), 32'd0);
    tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("rst_no_done", 0, 32'(dcnt[0] - d0), 32'd0);
    clear_q();
    pulse_start();
    wait_idle(400);
    check_a_lit("post_rst_seq");

    // start held high: back-to-back sessions with one IDLE cycle
    clear_q();
    d0 = dcnt[0];
    start = 1'b1;
    repeat (30) tick();
    start = 1'b0;
    wait_idle(400);
    chk("held_sessions", 0, 32'(dcnt[0] - d0), 32'd4);
    chk("held_len", 0, 32'(qa.size()), 32'd24);

`ifdef LBIST_TPG_SEED_LOAD_EN
    seed_in = 8'h08;
    seed_ld = 1'b1;
    tick();
    seed_ld = 1'b0;
    @(negedge clk);
    chk("seed_idle_pat", 0, 32'(ifa.pattern), 32'h08);
    tick();
    clear_q();
    pulse_start();
    seed_in = 8'h55;
    seed_ld = 1'b1;
    tick();
    seed_ld = 1'b0;
    wait_idle(400);
    chk("seed_len", 0, 32'(qa.size()), 32'd6);
    if (qa.size() >= 3) begin
      chk("seed_p0", 0, 32'(qa[0]), 32'h08);
      chk("seed_p1", 0, 32'(qa[1]), 32'h11);
      chk("seed_p2", 0, 32'(qa[2]), 32'h23);
    end
    seed_in = 8'h00;
    seed_ld = 1'b1;
    tick();
    seed_ld = 1'b0;
    clear_q();
    pulse_start();
    wait_idle(400);
    check_a_lit("seed_zero_seq");
`endif

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/lbist_tpg.md
Name: lbist_tpg

Overview:
- Test-pattern generator for the LBIST path; sits directly upstream of the 8-bit pattern buffer stage and drives its `inp` bus.
- An 8-bit Fibonacci LFSR produces a programmable number of pseudo-random patterns after a start pulse.
- Patterns are qualified by `pat_valid`. Completion is flagged by `done` so the downstream compactor and controller can close the session.

Parameters:
- WIDTH, 8: pattern/LFSR width; must match the downstream buffer input.
- TAPS, 8'hB8: feedback mask. Bit i set means q[i] is XORed into the feedback. Default taps are q[7],q[5],q[4],q[3] (x^8+x^6+x^5+x^4+1, maximal, period 255).
- SEED, 8'h01: reset and session-start LFSR value; must be non-zero.
- NPAT, 255: patterns per session, range 1..255.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  session request; sampled in IDLE only.
- hold  input  1  stall; freezes LFSR and counter while in RUN.
- pattern  output  WIDTH  current LFSR value; feeds the buffer stage's `inp`.
- pat_valid  output  1  pattern is a counted test vector this cycle.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse at session end.
- pat_idx  output  8  index of the current pattern, 0..NPAT-1.

Behaviour:
- Reset (async assert, synchronous-to-clk deassert usage): state=IDLE, pattern=SEED, pat_valid=0, busy=0, done=0, pat_idx=0.
- Feedback: fb = XOR-reduce(q & TAPS); next = {q[WIDTH-2:0], fb}.
  - From SEED 8'h01 the sequence is 01,02,04,08,11,23,...
- FSM states are IDLE, RUN, DONE.
- IDLE:
  - pattern held at SEED, pat_valid=0.
  - start=1 moves to RUN at the next edge. pattern=SEED, pat_idx=0.
- RUN:
  - busy=1; pat_valid = !hold.
  - Each edge with hold=0: LFSR advances and pat_idx increments.
  - Latency: first valid pattern (SEED) appears in the first RUN cycle, i.e. one cycle after start is sampled.
  - When pat_idx==NPAT-1 and hold=0: the next edge goes to DONE. The LFSR does not advance past the last pattern.
  - hold=1: pattern, pat_idx and state all frozen; pat_valid=0.
- DONE:
  - done=1 and busy=0 for exactly one cycle, pat_valid=0, pattern holds the last value.
  - Unconditional transition to IDLE, which reloads SEED.
- start while RUN or DONE: ignored, no restart.
- start held high continuously: a new session begins immediately after each IDLE visit. IDLE lasts 1 cycle minimum.
- NPAT=1: a single valid cycle (SEED), then DONE.
- NPAT=255: all 255 non-zero states are emitted exactly once; the zero state never appears.
- Reset mid-session: aborts immediately to the reset values; no done pulse.

Optional Feature:
- Macro: LBIST_TPG_SEED_LOAD_EN.
- Defined:
  - Adds ports `seed_in` (input, WIDTH) and `seed_ld` (input, 1).
  - seed_ld=1 in IDLE captures seed_in into a seed register used at every later session start.
  - A zero value is replaced by 8'h01 to avoid LFSR lockup.
  - seed_ld outside IDLE is ignored.
  - The seed register resets to SEED.
- Not defined: no extra ports; the SEED parameter is used for every session.

Decomposition:
- Shared package lbist_pkg holds:
  - the LBIST_W=8 constant;
  - the default TAPS and SEED constants;
  - the FSM state typedef (IDLE/RUN/DONE).
- Sub-module lbist_lfsr holds the LFSR register with load/advance/hold controls and a TAPS parameter. It is reusable by the downstream MISR.
- The FSM and counter live in lbist_tpg.

Test Plan:
- Reset then idle 5 cycles -> pattern=8'h01, pat_valid=0, busy=0, done=0 throughout.
- start pulse, NPAT=6, hold=0 -> pat_valid for 6 cycles with pattern 01,02,04,08,11,23; pat_idx 0..5; done=1 on the 7th cycle only; then IDLE with pattern=01.
- NPAT=255 full run -> 255 valid patterns, all distinct and non-zero; last pattern followed by a done pulse; total session is 256 cycles after start.
- hold=1 for 3 cycles after the 3rd pattern (04) -> pattern stays 04, pat_valid=0, pat_idx=2 frozen; after release the sequence resumes 04,08 with no pattern lost or duplicated in valid cycles.
- rst asserted during RUN at pat_idx=3 -> outputs take reset values immediately, no done pulse; a fresh start restarts from 01.
- With LBIST_TPG_SEED_LOAD_EN defined:
  - seed_ld with seed_in=8'h08, then start -> first patterns are 08,11,23.
  - seed_in=8'h00 loaded -> session starts from 01.
